// File: rtl/tdoa_pkg.sv
// tdoa_pkg: shared encodings for the TDOA estimator.
//   dir_*   : direction codes presented next to the averaged delta
//   state_t : pairing/calculation state machine encoding
package tdoa_pkg;

  localparam logic [1:0] DIR_CENTRE = 2'b00;
  localparam logic [1:0] DIR_MIC1   = 2'b01;
  localparam logic [1:0] DIR_MIC2   = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HAVE1 = 3'd1,
    HAVE2 = 3'd2,
    CALC  = 3'd3,
    ACCUM = 3'd4
  } state_t;

endpackage

// File: rtl/tdoa_pair_fsm.sv
// tdoa_pair_fsm: detects fresh timestamps on both channels, pairs one update
// from each, times out half-pairs and computes raw = t2 - t1 (mod 2^TS_WIDTH).
// Ports:
//   clock, reset      : clk2 domain, asynchronous active-high reset
//   time_1, time_2    : latest rising-edge timestamps per microphone
//   raw               : signed time difference, valid while raw_valid is high
//   raw_valid         : one-cycle strobe (state ACCUM)
//   timeout           : one-cycle pulse when a half-pair is abandoned
//   state             : current FSM state (debug visibility)
module tdoa_pair_fsm
  import tdoa_pkg::*;
#(
  parameter int TS_WIDTH = 32,
  parameter int TIMEOUT  = 5000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [TS_WIDTH-1:0]        time_1,
  input  logic [TS_WIDTH-1:0]        time_2,
  output logic signed [TS_WIDTH-1:0] raw,
  output logic                       raw_valid,
  output logic                       timeout,
  output state_t                     state
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t              state_d;
  logic                prime;
  logic [TS_WIDTH-1:0] prev_t1, prev_t2, t1_q, t2_q;
  logic [TW-1:0]       tcnt;
  logic                new_1, new_2;
  logic                cap1, cap2, tclr, tinc;

  // prime masks the first cycle after reset so inputs that were already
  // present during reset are not mistaken for new edges.
  assign new_1 = (time_1 != prev_t1) && !prime;
  assign new_2 = (time_2 != prev_t2) && !prime;

  always_comb begin
    state_d = state;
    cap1    = 1'b0;
    cap2    = 1'b0;
    tclr    = 1'b0;
    tinc    = 1'b0;
    timeout = 1'b0;
    unique case (state)
      IDLE: begin
        if (new_1 && new_2) begin
          cap1 = 1'b1; cap2 = 1'b1; state_d = CALC;
        end else if (new_1) begin
          cap1 = 1'b1; tclr = 1'b1; state_d = HAVE1;
        end else if (new_2) begin
          cap2 = 1'b1; tclr = 1'b1; state_d = HAVE2;
        end
      end
      HAVE1: begin
        if (new_2) begin
          cap2 = 1'b1; cap1 = new_1; state_d = CALC;
        end else if (new_1) begin
          cap1 = 1'b1; tclr = 1'b1;
        end else if (tcnt == TW'(TIMEOUT)) begin
          timeout = 1'b1; state_d = IDLE;
        end else begin
          tinc = 1'b1;
        end
      end
      HAVE2: begin
        if (new_1) begin
          cap1 = 1'b1; cap2 = new_2; state_d = CALC;
        end else if (new_2) begin
          cap2 = 1'b1; tclr = 1'b1;
        end else if (tcnt == TW'(TIMEOUT)) begin
          timeout = 1'b1; state_d = IDLE;
        end else begin
          tinc = 1'b1;
        end
      end
      CALC:    state_d = ACCUM;
      ACCUM:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      prime   <= 1'b1;
      prev_t1 <= '0;
      prev_t2 <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      tcnt    <= '0;
      raw     <= '0;
    end else begin
      state   <= state_d;
      prime   <= 1'b0;
      prev_t1 <= time_1;
      prev_t2 <= time_2;
      if (cap1) t1_q <= time_1;
      if (cap2) t2_q <= time_2;
      if (tclr)      tcnt <= '0;
      else if (tinc) tcnt <= tcnt + 1'b1;
      // Modular subtraction read as two's complement absorbs counter wrap.
      if (state == CALC) raw <= t2_q - t1_q;
    end
  end

  assign raw_valid = (state == ACCUM);

endmodule

// File: rtl/tdoa_estimator.sv
// tdoa_estimator: pairs mic timestamps, window-checks each delta, averages
// 2^AVG_LOG2 accepted deltas and presents the result to the GPIO.
// Handshake: avg_valid rises with each new delta_avg/direction and stays high
// until a one-cycle avg_ack; a load arriving while valid without ack overwrites
// and sets sticky overrun; load and ack together keep avg_valid high with no
// overrun.
// Ports:
//   clock, reset         : clk2, asynchronous active-high reset
//   time_1, time_2       : timestamps from the phase detector
//   avg_ack              : average consumed
//   delta_avg            : signed average of (time_2 - time_1)
//   avg_valid, overrun   : handshake status
//   direction            : centre / toward mic 1 / toward mic 2
//   reject_count         : saturating count of rejected or timed-out pairs
//   fsm_state            : pairing state (debug visibility)
module tdoa_estimator
  import tdoa_pkg::*;
#(
  parameter int TS_WIDTH    = 32,
  parameter int DELTA_WIDTH = 16,
  parameter int MAX_DELAY   = 300,
  parameter int TIMEOUT     = 5000,
  parameter int AVG_LOG2    = 2,
  parameter int DEADBAND    = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [TS_WIDTH-1:0]           time_1,
  input  logic [TS_WIDTH-1:0]           time_2,
  input  logic                          avg_ack,
  output logic signed [DELTA_WIDTH-1:0] delta_avg,
  output logic                          avg_valid,
  output logic [1:0]                    direction,
  output logic                          overrun,
  output logic [7:0]                    reject_count,
  output state_t                        fsm_state
);

  localparam int ACC_W = DELTA_WIDTH + AVG_LOG2;
  localparam int NSAMP = 1 << AVG_LOG2;
  localparam logic signed [TS_WIDTH-1:0]    MAX_POS = TS_WIDTH'(MAX_DELAY);
  localparam logic signed [TS_WIDTH-1:0]    MAX_NEG = -MAX_POS;
  localparam logic signed [DELTA_WIDTH-1:0] DB_POS  = DELTA_WIDTH'(DEADBAND);
  localparam logic signed [DELTA_WIDTH-1:0] DB_NEG  = -DB_POS;

  logic signed [TS_WIDTH-1:0]    raw;
  logic                          raw_valid, timeout;
  logic signed [ACC_W-1:0]       acc, acc_sum, acc_shift;
  logic [AVG_LOG2:0]             count;
  logic signed [DELTA_WIDTH-1:0] avg_next;
  logic [1:0]                    dir_next;
  logic                          in_window, accept, load, reject;

  tdoa_pair_fsm #(
    .TS_WIDTH (TS_WIDTH),
    .TIMEOUT  (TIMEOUT)
  ) u_pair (
    .clock     (clock),
    .reset     (reset),
    .time_1    (time_1),
    .time_2    (time_2),
    .raw       (raw),
    .raw_valid (raw_valid),
    .timeout   (timeout),
    .state     (fsm_state)
  );

  always_comb begin
    in_window = (raw <= MAX_POS) && (raw >= MAX_NEG);
    accept    = raw_valid && in_window;
    reject    = timeout || (raw_valid && !in_window);
    load      = accept && (count == (AVG_LOG2+1)'(NSAMP - 1));
    acc_sum   = acc + $signed({{AVG_LOG2{raw[DELTA_WIDTH-1]}}, raw[DELTA_WIDTH-1:0]});
    // Arithmetic shift floors toward -inf; the result always fits DELTA_WIDTH.
    acc_shift = acc_sum >>> AVG_LOG2;
    avg_next  = acc_shift[DELTA_WIDTH-1:0];
    if (avg_next > DB_POS)      dir_next = DIR_MIC1;
    else if (avg_next < DB_NEG) dir_next = DIR_MIC2;
    else                        dir_next = DIR_CENTRE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc          <= '0;
      count        <= '0;
      delta_avg    <= '0;
      direction    <= DIR_CENTRE;
      avg_valid    <= 1'b0;
      overrun      <= 1'b0;
      reject_count <= '0;
    end else begin
      if (load) begin
        acc       <= '0;
        count     <= '0;
        delta_avg <= avg_next;
        direction <= dir_next;
      end else if (accept) begin
        acc   <= acc_sum;
        count <= count + 1'b1;
      end

      if (load)         avg_valid <= 1'b1;
      else if (avg_ack) avg_valid <= 1'b0;

      if (avg_ack)                overrun <= 1'b0;
      else if (load && avg_valid) overrun <= 1'b1;

      if (reject && reject_count != 8'hFF) reject_count <= reject_count + 1'b1;
    end
  end

endmodule
